regfile_param: RTL and testbench

Parametrised general-purpose register file for the single-cycle processor datapath, generalising the fixed 32x32, two-read/one-write register file. It has a configurable data width, register count and read-port count, and writes on the rising clock edge. It adds a hardware clear sequencer, entered on reset or on request, that zeroes every register one entry per cycle. An optional write-to-read bypass is available. It sits between instruction decode (addresses) and the ALU and writeback mux (data).

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_if.sv | 30 +++
 rtl/regfile_read_port.sv | 40 ++++
 rtl/regfile_param.sv | 96 +++++++++
 tb/tb_regfile_param.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the parametrised register file.
package regfile_pkg;

  typedef enum logic {
    RF_INIT  = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

  localparam int RF_XLEN = 32;
  localparam int RF_NREG = 32;

endpackage

// File: rtl/regfile_if.sv
// Decode/writeback-side bus of the register file: read addresses/data, write port, clear control.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int NREG = RF_NREG,
  parameter int NRD  = 2
) ();

  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                clear_req;
  logic                init_busy;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, clear_req,
    input  rd_data, init_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, clear_req,
    output rd_data, init_busy
  );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: zero-register, range and init_busy masking.
// Optional same-cycle write-through when REGFILE_BYPASS_EN is defined.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int NREG = RF_NREG,
  parameter int AW   = $clog2(NREG)
) (
  input  logic [XLEN-1:0] mem [NREG],
  input  logic            init_busy,
  input  logic [AW-1:0]   rd_addr,
  input  logic            wr_ok,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  output logic [XLEN-1:0] rd_data
);

  localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

  logic in_range;
  assign in_range = ({1'b0, rd_addr} < NREG_W);

  always_comb begin
    rd_data = '0;
    if (!init_busy && (rd_addr != '0) && in_range) begin
`ifdef REGFILE_BYPASS_EN
      rd_data = (wr_ok && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
`else
      rd_data = mem[rd_addr];
`endif
    end
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_byp;
  assign unused_byp = ^{wr_ok, wr_addr, wr_data};
`endif

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file with a one-entry-per-cycle clear sequencer.
// Optional write-to-read bypass: define REGFILE_BYPASS_EN.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int NREG = RF_NREG,
  parameter int NRD  = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  regfile_if.slave  bus
);

  localparam int          AW     = $clog2(NREG);
  localparam logic [AW-1:0] LAST = AW'(NREG - 1);
  localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

  rf_state_t           state_q, state_d;
  logic [AW-1:0]       clr_idx_q, clr_idx_d;
  logic                init_busy_q, busy_d;
  logic                clr_we, wr_ok;
  logic [XLEN-1:0]     mem [NREG];
  logic [NRD*XLEN-1:0] rd_data_w;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RF_INIT;
      clr_idx_q   <= '0;
      init_busy_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      init_busy_q <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      RF_INIT: begin
        if (clr_idx_q == LAST) begin
          state_d   = RF_READY;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      RF_READY: begin
        if (bus.clear_req) begin
          state_d   = RF_INIT;
          clr_idx_d = '0;
        end
      end
    endcase
  end

  // Entry 0 is hardwired to zero, so neither the clear nor a write ever touches it.
  always_comb begin
    busy_d = (state_d == RF_INIT);
    clr_we = (state_q == RF_INIT) && (clr_idx_q != '0);
    wr_ok  = (state_q == RF_READY) && bus.wr_en && (bus.wr_addr != '0) &&
             ({1'b0, bus.wr_addr} < NREG_W);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (clr_we) begin
        mem[clr_idx_q] <= '0;
      end else if (wr_ok) begin
        mem[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_read_port #(
      .XLEN (XLEN),
      .NREG (NREG),
      .AW   (AW)
    ) u_rd (
      .mem       (mem),
      .init_busy (init_busy_q),
      .rd_addr   (bus.rd_addr[k*AW +: AW]),
      .wr_ok     (wr_ok),
      .wr_addr   (bus.wr_addr),
      .wr_data   (bus.wr_data),
      .rd_data   (rd_data_w[k*XLEN +: XLEN])
    );
  end

  assign bus.rd_data   = rd_data_w;
  assign bus.init_busy = init_busy_q;

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench: default 32x32/2-port instance plus a 24x16/3-port instance.
module tb_regfile_param;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  regfile_if #(.XLEN(32), .NREG(32), .NRD(2)) ba ();
  regfile_if #(.XLEN(16), .NREG(24), .NRD(3)) bb ();

  regfile_param #(.XLEN(32), .NREG(32), .NRD(2)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ba)
  );

  regfile_param #(.XLEN(16), .NREG(24), .NRD(3)) u_b (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (bb)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [4:0] a, input logic [31:0] d);
    ba.wr_en   = 1'b1;
    ba.wr_addr = a;
    ba.wr_data = d;
    tick();
    ba.wr_en   = 1'b0;
  endtask

  task automatic wr_b(input logic [4:0] a, input logic [15:0] d);
    bb.wr_en   = 1'b1;
    bb.wr_addr = a;
    bb.wr_data = d;
    tick();
    bb.wr_en   = 1'b0;
  endtask

  task automatic rd_a(input logic [4:0] a0, input logic [4:0] a1);
    ba.rd_addr = {a1, a0};
    #1;
  endtask

  // Counts edges until init_busy drops; optionally injects a write and a clear_req mid-clear.
  task automatic count_a(input bit inject, output int n);
    n = 0;
    while (ba.init_busy && n < 100) begin
      if (inject && n == 3) begin
        ba.wr_en = 1'b1; ba.wr_addr = 5'd3; ba.wr_data = 32'hCAFE_0003;
      end
      if (inject && n == 4) ba.wr_en = 1'b0;
      if (inject && n == 6) ba.clear_req = 1'b1;
      if (inject && n == 7) ba.clear_req = 1'b0;
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; rst2_n = 1'b0;
    ba.rd_addr = '0; ba.wr_en = 1'b0; ba.wr_addr = '0; ba.wr_data = '0; ba.clear_req = 1'b0;
    bb.rd_addr = '0; bb.wr_en = 1'b0; bb.wr_addr = '0; bb.wr_data = '0; bb.clear_req = 1'b0;

    // Reset and initial clear
    tick(); tick();
    chk("rst_busy", {31'b0, ba.init_busy}, 32'd1);
    rd_a(5'd7, 5'd31);
    chk("rst_rd0", ba.rd_data[31:0], 32'h0);
    chk("rst_rd1", ba.rd_data[63:32], 32'h0);
    rst_n = 1'b1;
    count_a(1'b0, n);
    chk("clr_len", n, 32'd32);
    for (int a = 0; a < 32; a++) begin
      rd_a(5'(a), 5'(31 - a));
      chk("post_clr_rd0", ba.rd_data[31:0], 32'h0);
      chk("post_clr_rd1", ba.rd_data[63:32], 32'h0);
    end

    // Basic write/read, r0 hardwired
    wr_a(5'd5, 32'hDEAD_BEEF);
    rd_a(5'd5, 5'd5);
    chk("r5_p0", ba.rd_data[31:0], 32'hDEAD_BEEF);
    chk("r5_p1", ba.rd_data[63:32], 32'hDEAD_BEEF);
    wr_a(5'd0, 32'd7);
    rd_a(5'd5, 5'd0);
    chk("r0_p1", ba.rd_data[63:32], 32'h0);
    wr_a(5'd31, 32'h1234_5678);
    rd_a(5'd31, 5'd5);
    chk("r31_p0", ba.rd_data[31:0], 32'h1234_5678);
    chk("r5_keep", ba.rd_data[63:32], 32'hDEAD_BEEF);

    // Same-cycle read/write hazard on r9
    wr_a(5'd9, 32'h11);
    ba.wr_en = 1'b1; ba.wr_addr = 5'd9; ba.wr_data = 32'h55;
    rd_a(5'd9, 5'd5);
`ifdef REGFILE_BYPASS_EN
    chk("hazard_r9", ba.rd_data[31:0], 32'h55);
`else
    chk("hazard_r9", ba.rd_data[31:0], 32'h11);
`endif
    chk("hazard_other", ba.rd_data[63:32], 32'hDEAD_BEEF);
    tick();
    ba.wr_en = 1'b0;
    rd_a(5'd9, 5'd9);
    chk("r9_after", ba.rd_data[31:0], 32'h55);

    // Fill, then clear_req with a dropped write and an ignored re-request
    for (int a = 1; a < 32; a++) wr_a(5'(a), 32'h0101_0101 * a);
    rd_a(5'd3, 5'd30);
    chk("fill_r3", ba.rd_data[31:0], 32'h0303_0303);
    chk("fill_r30", ba.rd_data[63:32], 32'h1E1E_1E1E);
    ba.clear_req = 1'b1;
    tick();
    ba.clear_req = 1'b0;
    chk("creq_busy", {31'b0, ba.init_busy}, 32'd1);
    chk("creq_mask", ba.rd_data[31:0], 32'h0);
    count_a(1'b1, n);
    chk("creq_len", n, 32'd32);
    for (int a = 1; a < 32; a++) begin
      rd_a(5'(a), 5'd3);
      chk("creq_rd", ba.rd_data[31:0], 32'h0);
    end
    chk("creq_r3", ba.rd_data[63:32], 32'h0);

    // Reset mid-clear restarts the full sequence
    wr_a(5'd4, 32'hAAAA_0004);
    ba.clear_req = 1'b1;
    tick();
    ba.clear_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_busy", {31'b0, ba.init_busy}, 32'd1);
    rst_n = 1'b1;
    count_a(1'b0, n);
    chk("midrst_len", n, 32'd32);
    rd_a(5'd4, 5'd31);
    chk("midrst_r4", ba.rd_data[31:0], 32'h0);

    // Sweep instance: NREG=24, NRD=3, XLEN=16
    rst2_n = 1'b1;
    n = 0;
    while (bb.init_busy && n < 100) begin
      tick();
      n++;
    end
    chk("b_clr_len", n, 32'd24);
    wr_b(5'd1, 16'h1111);
    wr_b(5'd2, 16'h2222);
    wr_b(5'd23, 16'h2323);
    wr_b(5'd30, 16'hBEEF);
    bb.rd_addr = {5'd23, 5'd2, 5'd1};
    #1;
    chk("b_p0", {16'b0, bb.rd_data[15:0]}, 32'h1111);
    chk("b_p1", {16'b0, bb.rd_data[31:16]}, 32'h2222);
    chk("b_p2", {16'b0, bb.rd_data[47:32]}, 32'h2323);
    bb.rd_addr = {5'd30, 5'd24, 5'd0};
    #1;
    chk("b_r0", {16'b0, bb.rd_data[15:0]}, 32'h0);
    chk("b_r24", {16'b0, bb.rd_data[31:16]}, 32'h0);
    chk("b_r30", {16'b0, bb.rd_data[47:32]}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
